// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  // Fetch FSM states: issue request, wait for data, hold data in skid buffer.
  typedef enum logic [1:0] {
    IF_S_REQ  = 2'd0,
    IF_S_WAIT = 2'd1,
    IF_S_HOLD = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  // Word-align a control-flow target; the low two bits are never honoured.
  function automatic logic [31:0] pc_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush > load > stall-hold > bubble.
import if_stage_pkg::*;

module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  input  logic        stall,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  // Pipeline register update with fixed priority; pc is left untouched when invalid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (stall && valid) begin
      valid <= valid;
    end else begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request,
// applies EX redirects and feeds the IF/ID register.
import if_stage_pkg::*;

module if_stage #(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o
);

  if_state_e   state, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill, kill_d;
  logic [31:0] skid_pc, skid_pc_d;
  logic [31:0] skid_instr, skid_instr_d;
  logic        load;
  logic [31:0] load_pc, load_instr;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        if_id_free;

  assign target     = pc_align(redirect_pc_i);
  assign pc_plus4   = pc_q + 32'd4;
  assign if_id_free = ~stall_i | ~if_id_valid_o;

  // Request is gated by rstn so nothing is issued while reset is asserted.
  assign imem_req_o  = rstn & (state == IF_S_REQ) & ~redirect_i;
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;

  // State, PC, kill flag and skid buffer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IF_S_REQ;
      pc_q       <= RESET_PC;
      kill       <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else begin
      state      <= state_d;
      pc_q       <= pc_d;
      kill       <= kill_d;
      skid_pc    <= skid_pc_d;
      skid_instr <= skid_instr_d;
    end
  end

  // Next-state logic and IF/ID load selection.
  always_comb begin
    state_d      = state;
    pc_d         = pc_q;
    kill_d       = kill;
    skid_pc_d    = skid_pc;
    skid_instr_d = skid_instr;
    load         = 1'b0;
    load_pc      = pc_q;
    load_instr   = imem_rdata_i;
    unique case (state)
      IF_S_REQ: begin
        if (redirect_i) begin
          pc_d = target;
        end else if (imem_gnt_i) begin
          state_d = IF_S_WAIT;
        end
      end
      IF_S_WAIT: begin
        if (redirect_i && imem_rvalid_i) begin
          // The arriving response belongs to the superseded request, so any
          // pending kill is also consumed here.
          pc_d    = target;
          kill_d  = 1'b0;
          state_d = IF_S_REQ;
        end else if (redirect_i) begin
          kill_d = 1'b1;
          pc_d   = target;
        end else if (imem_rvalid_i && kill) begin
          kill_d  = 1'b0;
          state_d = IF_S_REQ;
        end else if (imem_rvalid_i && if_id_free) begin
          load    = 1'b1;
          pc_d    = pc_plus4;
          state_d = IF_S_REQ;
        end else if (imem_rvalid_i) begin
          skid_pc_d    = pc_q;
          skid_instr_d = imem_rdata_i;
          state_d      = IF_S_HOLD;
        end
      end
      IF_S_HOLD: begin
        if (redirect_i) begin
          pc_d    = target;
          state_d = IF_S_REQ;
        end else if (!stall_i) begin
          load       = 1'b1;
          load_pc    = skid_pc;
          load_instr = skid_instr;
          pc_d       = pc_plus4;
          state_d    = IF_S_REQ;
        end
      end
      default: begin
        state_d = IF_S_REQ;
      end
    endcase
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (redirect_i),
    .load      (load),
    .load_pc   (load_pc),
    .load_instr(load_instr),
    .stall     (stall_i),
    .valid     (if_id_valid_o),
    .pc        (if_id_pc_o),
    .instr     (if_id_instr_o)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rstn;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic        if_id_valid_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_instr_o;

  int checks;
  int errors;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .stall_i      (stall_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .pc_o         (pc_o),
    .if_id_valid_o(if_id_valid_o),
    .if_id_pc_o   (if_id_pc_o),
    .if_id_instr_o(if_id_instr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a word derived from its address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        stall;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;    // before the edge
    logic [31:0] e_addr;   // before the edge
    logic        e_valid;  // after the edge
    logic [31:0] e_pc;     // after the edge, checked when valid
    logic [31:0] e_instr;  // after the edge
  } vec_t;

  localparam int NV = 32;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic stall,
                              input logic gnt, input logic rvalid, input logic [31:0] rdata,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc,
                              input logic [31:0] e_instr);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.stall = stall; v.gnt = gnt;
    v.rvalid = rvalid; v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr;
    v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic redir, input logic [31:0] rpc, input logic stall,
                       input logic gnt, input logic rvalid, input logic [31:0] rdata);
    redirect_i    = redir;
    redirect_pc_i = rpc;
    stall_i       = stall;
    imem_gnt_i    = gnt;
    imem_rvalid_i = rvalid;
    imem_rdata_i  = rdata;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);

    //                redir rpc            stall gnt rv  rdata                 req addr           valid pc              instr
    vecs[0]  = mk(1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 32'h0,              1'b1, 32'h0,          1'b0, 32'h0,          NOP);
    vecs[1]  = mk(1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 32'h0,              1'b1, 32'h0,          1'b0, 32'h0,          NOP);
    vecs[2]  = mk(1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 32'h0,              1'b1, 32'h0,          1'b0, 32'h0,          NOP);
    vecs[3]  = mk(1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 32'h0,              1'b1, 32'h0,          1'b0, 32'h0,          NOP);
    vecs[4]  = mk(1'b0, 32'h0,          1'b0, 1'b0, 1'b1, mem(32'h0),         1'b0, 32'h0,          1'b1, 32'h0,          mem(32'h0));
    vecs[5]  = mk(1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 32'h0,              1'b1, 32'h4,          1'b0, 32'h0,          NOP);
    vecs[6]  = mk(1'b0, 32'h0,          1'b0, 1'b0, 1'b1, mem(32'h4),         1'b0, 32'h4,          1'b1, 32'h4,          mem(32'h4));
    vecs[7]  = mk(1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 32'h0,              1'b1, 32'h8,          1'b0, 32'h0,          NOP);
    vecs[8]  = mk(1'b0, 32'h0,          1'b0, 1'b0, 1'b1, mem(32'h8),         1'b0, 32'h8,          1'b1, 32'h8,          mem(32'h8));
    // stall holds IF/ID, response goes to the skid buffer
    vecs[9]  = mk(1'b0, 32'h0,          1'b1, 1'b1, 1'b0, 32'h0,              1'b1, 32'hC,          1'b1, 32'h8,          mem(32'h8));
    vecs[10] = mk(1'b0, 32'h0,          1'b1, 1'b0, 1'b1, mem(32'hC),         1'b0, 32'hC,          1'b1, 32'h8,          mem(32'h8));
    vecs[11] = mk(1'b0, 32'h0,          1'b1, 1'b1, 1'b0, 32'h0,              1'b0, 32'hC,          1'b1, 32'h8,          mem(32'h8));
    vecs[12] = mk(1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 32'h0,              1'b0, 32'hC,          1'b1, 32'hC,          mem(32'hC));
    vecs[13] = mk(1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 32'h0,              1'b1, 32'h10,         1'b0, 32'h0,          NOP);
    // redirect in WAIT, stale response two cycles later
    vecs[14] = mk(1'b1, 32'h103,        1'b0, 1'b0, 1'b0, 32'h0,              1'b0, 32'h10,         1'b0, 32'h0,          NOP);
    vecs[15] = mk(1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 32'h0,              1'b0, 32'h100,        1'b0, 32'h0,          NOP);
    vecs[16] = mk(1'b0, 32'h0,          1'b0, 1'b0, 1'b1, mem(32'h10),        1'b0, 32'h100,        1'b0, 32'h0,          NOP);
    vecs[17] = mk(1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 32'h0,              1'b1, 32'h100,        1'b0, 32'h0,          NOP);
    vecs[18] = mk(1'b0, 32'h0,          1'b0, 1'b0, 1'b1, mem(32'h100),       1'b0, 32'h100,        1'b1, 32'h100,        mem(32'h100));
    vecs[19] = mk(1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 32'h0,              1'b1, 32'h104,        1'b0, 32'h0,          NOP);
    // redirect together with rvalid: data dropped, no kill
    vecs[20] = mk(1'b1, 32'h200,        1'b0, 1'b0, 1'b1, mem(32'h104),       1'b0, 32'h104,        1'b0, 32'h0,          NOP);
    vecs[21] = mk(1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 32'h0,              1'b1, 32'h200,        1'b0, 32'h0,          NOP);
    // redirect in REQ overrides a grant
    vecs[22] = mk(1'b1, 32'h301,        1'b0, 1'b1, 1'b0, 32'h0,              1'b0, 32'h200,        1'b0, 32'h0,          NOP);
    vecs[23] = mk(1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 32'h0,              1'b1, 32'h300,        1'b0, 32'h0,          NOP);
    vecs[24] = mk(1'b0, 32'h0,          1'b0, 1'b0, 1'b1, mem(32'h300),       1'b0, 32'h300,        1'b1, 32'h300,        mem(32'h300));
    // redirect flushes a stalled valid IF/ID
    vecs[25] = mk(1'b1, 32'h400,        1'b1, 1'b0, 1'b0, 32'h0,              1'b0, 32'h304,        1'b0, 32'h0,          NOP);
    vecs[26] = mk(1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 32'h0,              1'b1, 32'h400,        1'b0, 32'h0,          NOP);
    vecs[27] = mk(1'b0, 32'h0,          1'b0, 1'b0, 1'b1, mem(32'h400),       1'b0, 32'h400,        1'b1, 32'h400,        mem(32'h400));
    // PC wrap at the top of the address space
    vecs[28] = mk(1'b1, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0, 32'h0,              1'b0, 32'h404,        1'b0, 32'h0,          NOP);
    vecs[29] = mk(1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 32'h0,              1'b1, 32'hFFFF_FFFC,  1'b0, 32'h0,          NOP);
    vecs[30] = mk(1'b0, 32'h0,          1'b0, 1'b0, 1'b1, mem(32'hFFFF_FFFC), 1'b0, 32'hFFFF_FFFC,  1'b1, 32'hFFFF_FFFC,  mem(32'hFFFF_FFFC));
    vecs[31] = mk(1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 32'h0,              1'b1, 32'h0,          1'b0, 32'h0,          NOP);

    // Reset state
    #12;
    chk("rst_req",   {31'b0, imem_req_o},    32'h0);
    chk("rst_pc",    pc_o,                   32'h0);
    chk("rst_valid", {31'b0, if_id_valid_o}, 32'h0);
    chk("rst_ifpc",  if_id_pc_o,             32'h0);
    chk("rst_instr", if_id_instr_o,          NOP);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].redir, vecs[i].rpc, vecs[i].stall, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d_req", i),  {31'b0, imem_req_o}, {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d_addr", i), imem_addr_o, vecs[i].e_addr);
      chk($sformatf("v%0d_pco", i),  pc_o, vecs[i].e_addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'b0, if_id_valid_o}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d_instr", i), if_id_instr_o, vecs[i].e_instr);
      chk($sformatf("v%0d_align", i), {30'b0, if_id_pc_o[1:0]}, 32'h0);
      if (vecs[i].e_valid) chk($sformatf("v%0d_ifpc", i), if_id_pc_o, vecs[i].e_pc);
    end

    // Bring the stage into S_HOLD at pc 4 with IF/ID holding pc 0, then pulse rstn.
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b0, 1'b1, mem(32'h0));
    @(negedge clk); drive(1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
    @(negedge clk); drive(1'b0, '0, 1'b1, 1'b0, 1'b1, mem(32'h4));
    @(posedge clk); #1;
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    chk("hold_valid", {31'b0, if_id_valid_o}, 32'h1);
    chk("hold_ifpc",  if_id_pc_o,             32'h0);
    chk("hold_pc",    pc_o,                   32'h4);
    chk("hold_req",   {31'b0, imem_req_o},    32'h0);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", {31'b0, if_id_valid_o}, 32'h0);
    chk("arst_instr", if_id_instr_o,          NOP);
    chk("arst_ifpc",  if_id_pc_o,             32'h0);
    chk("arst_pc",    pc_o,                   32'h0);
    chk("arst_req",   {31'b0, imem_req_o},    32'h0);
    @(negedge clk);
    rstn = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    #1;
    chk("post_req",  {31'b0, imem_req_o}, 32'h1);
    chk("post_addr", imem_addr_o,         32'h0);
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b0, 1'b1, mem(32'h0));
    @(posedge clk); #1;
    chk("post_valid", {31'b0, if_id_valid_o}, 32'h1);
    chk("post_ifpc",  if_id_pc_o,             32'h0);
    chk("post_instr", if_id_instr_o,          mem(32'h0));
    chk("post_pc",    pc_o,                   32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
